cam_manager: RTL and testbench

Command front-end placed directly upstream of the block-RAM CAM. It accepts insert, delete, lookup and clear commands on a valid/ready port, tracks which CAM entries are occupied, and allocates the lowest free entry on insert. It drives the CAM's write, delete, clear and compare inputs, honours the CAM's `write_busy`, and returns one status response per command.

---
 rtl/cam_manager_pkg.sv | 28 ++
 rtl/cam_manager_if.sv | 25 ++
 rtl/priority_encoder.sv | 42 ++++
 rtl/cam_manager.sv | 208 ++++++++++++++++++++
 tb/tb_cam_manager.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_manager_pkg.sv
// cam_manager_pkg: shared opcode, status and FSM state encodings for cam_manager.
// No ports; imported by the interface, the top and the bench.
package cam_manager_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_INSERT = 2'd0;
    localparam logic [1:0] OP_DELETE = 2'd1;
    localparam logic [1:0] OP_LOOKUP = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    // Response status codes carried on rsp_status
    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_FULL     = 2'd1;
    localparam logic [1:0] ST_NOTFOUND = 2'd2;
    localparam logic [1:0] ST_DUP      = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_WRITE  = 3'd2,
        S_DELETE = 3'd3,
        S_CLR    = 3'd4,
        S_WAIT_G = 3'd5,
        S_WAIT   = 3'd6,
        S_RESP   = 3'd7
    } state_t;

endpackage

// File: rtl/cam_manager_if.sv
// cam_manager_if: command/response port of cam_manager.
//   cmd_valid/cmd_ready/cmd_op/cmd_key : command handshake (master -> slave)
//   rsp_valid/rsp_status/rsp_addr      : one response pulse per accepted command
interface cam_manager_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_key;
    logic                  rsp_valid;
    logic [1:0]            rsp_status;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_key,
        input  cmd_ready, rsp_valid, rsp_status, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key,
        output cmd_ready, rsp_valid, rsp_status, rsp_addr
    );
endinterface

// File: rtl/priority_encoder.sv
// priority_encoder: returns the index of a set bit in i_input_unencoded.
//   LSB_PRIORITY = "HIGH" -> lowest set index wins, otherwise highest wins.
//   i_input_unencoded : request vector
//   o_output_valid    : any bit set
//   o_output_encoded  : winning index (0 when none set)
module priority_encoder #(
    parameter int    WIDTH        = 4,
    parameter string LSB_PRIORITY = "LOW"
) (
    input  logic [WIDTH-1:0] i_input_unencoded,
    output logic             o_output_valid,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] o_output_encoded
);
    localparam int unsigned ENC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (LSB_PRIORITY == "HIGH") begin : g_lsb_high
            // Scan downwards so the last hit is the lowest index
            always_comb begin
                o_output_valid   = 1'b0;
                o_output_encoded = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (i_input_unencoded[i]) begin
                        o_output_valid   = 1'b1;
                        o_output_encoded = ENC_W'(i);
                    end
                end
            end
        end else begin : g_lsb_low
            always_comb begin
                o_output_valid   = 1'b0;
                o_output_encoded = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i_input_unencoded[i]) begin
                        o_output_valid   = 1'b1;
                        o_output_encoded = ENC_W'(i);
                    end
                end
            end
        end
    endgenerate
endmodule

// File: rtl/cam_manager.sv
// cam_manager: command front-end for the block-RAM CAM. Tracks occupied
// entries, allocates the lowest free entry on insert, sequences CAM writes,
// deletes and clears, and returns one status response per command.
//   clk, rst            : clock, synchronous active-high reset (shared with CAM)
//   cmd_if (slave)      : command handshake and response
//   o_occupancy         : number of valid entries
//   o_cam_write_*       : CAM write side (addr, data, delete, enable)
//   o_cam_rst_clr       : CAM clear strobe
//   i_cam_write_busy    : CAM busy flag
//   o_cam_compare_data  : CAM search key
//   i_cam_match(_addr)  : CAM search result
module cam_manager
    import cam_manager_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    cam_manager_if.slave          cmd_if,
    output logic [ADDR_WIDTH:0]   o_occupancy,
    output logic [ADDR_WIDTH-1:0] o_cam_write_addr,
    output logic [DATA_WIDTH-1:0] o_cam_write_data,
    output logic                  o_cam_write_delete,
    output logic                  o_cam_write_enable,
    output logic                  o_cam_rst_clr,
    input  logic                  i_cam_write_busy,
    output logic [DATA_WIDTH-1:0] o_cam_compare_data,
    input  logic [ADDR_WIDTH-1:0] i_cam_match_addr,
    input  logic                  i_cam_match
);
    localparam int unsigned ENTRIES = 2 ** ADDR_WIDTH;
    localparam int unsigned OCC_W   = ADDR_WIDTH + 1;

    state_t                r_state, w_state_next;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_key;
    logic [ADDR_WIDTH-1:0] r_alloc;
    logic [ADDR_WIDTH-1:0] r_match_addr;
    logic [ENTRIES-1:0]    r_valid_vec, w_valid_next;
    logic [OCC_W-1:0]      r_occupancy, w_occ_next;
    logic                  r_rsp_valid;
    logic [1:0]            r_rsp_status, w_rsp_status_next;
    logic [ADDR_WIDTH-1:0] r_rsp_addr, w_rsp_addr_next;
    logic                  r_cam_we, r_cam_del, r_cam_clr;
    logic [ADDR_WIDTH-1:0] r_cam_addr;
    logic                  w_cmd_ready;
    logic [ENTRIES-1:0]    w_free_vec;
    logic                  w_free_valid;
    logic [ADDR_WIDTH-1:0] w_free_idx;

    // Lowest free entry; no valid output means the table is full
    assign w_free_vec = ~r_valid_vec;

    priority_encoder #(
        .WIDTH        (ENTRIES),
        .LSB_PRIORITY ("HIGH")
    ) u_free_enc (
        .i_input_unencoded (w_free_vec),
        .o_output_valid    (w_free_valid),
        .o_output_encoded  (w_free_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, response status and bookkeeping update
    always_comb begin
        w_state_next      = r_state;
        w_rsp_status_next = r_rsp_status;
        w_rsp_addr_next   = r_rsp_addr;
        w_valid_next      = r_valid_vec;
        w_cmd_ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = !i_cam_write_busy;
                if (cmd_if.cmd_valid && w_cmd_ready) begin
                    w_state_next = (cmd_if.cmd_op == OP_CLEAR) ? S_CLR : S_SEARCH;
                end
            end
            S_SEARCH: begin
                case (r_op)
                    OP_LOOKUP: begin
                        w_state_next      = S_RESP;
                        w_rsp_status_next = i_cam_match ? ST_OK : ST_NOTFOUND;
                        w_rsp_addr_next   = i_cam_match ? i_cam_match_addr : '0;
                    end
                    OP_INSERT: begin
                        if (i_cam_match) begin
                            w_state_next      = S_RESP;
                            w_rsp_status_next = ST_DUP;
                            w_rsp_addr_next   = i_cam_match_addr;
                        end else if (!w_free_valid) begin
                            w_state_next      = S_RESP;
                            w_rsp_status_next = ST_FULL;
                            w_rsp_addr_next   = '0;
                        end else begin
                            w_state_next = S_WRITE;
                        end
                    end
                    OP_DELETE: begin
                        if (i_cam_match) begin
                            w_state_next = S_DELETE;
                        end else begin
                            w_state_next      = S_RESP;
                            w_rsp_status_next = ST_NOTFOUND;
                            w_rsp_addr_next   = '0;
                        end
                    end
                    default: w_state_next = S_IDLE;
                endcase
            end
            S_WRITE, S_DELETE, S_CLR: w_state_next = S_WAIT_G;
            // Busy may not have risen yet right after the strobe
            S_WAIT_G: w_state_next = S_WAIT;
            S_WAIT: begin
                if (!i_cam_write_busy) begin
                    w_state_next      = S_RESP;
                    w_rsp_status_next = ST_OK;
                    case (r_op)
                        OP_INSERT: begin
                            w_valid_next[r_alloc] = 1'b1;
                            w_rsp_addr_next       = r_alloc;
                        end
                        OP_DELETE: begin
                            w_valid_next[r_match_addr] = 1'b0;
                            w_rsp_addr_next            = r_match_addr;
                        end
                        default: begin
                            w_valid_next    = '0;
                            w_rsp_addr_next = '0;
                        end
                    endcase
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Population count of the post-update vector so occupancy lines up with rsp_valid
    always_comb begin
        w_occ_next = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            w_occ_next = w_occ_next + OCC_W'(w_valid_next[i]);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= '0;
            r_key        <= '0;
            r_alloc      <= '0;
            r_match_addr <= '0;
            r_valid_vec  <= '0;
            r_occupancy  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= '0;
            r_rsp_addr   <= '0;
            r_cam_we     <= 1'b0;
            r_cam_del    <= 1'b0;
            r_cam_clr    <= 1'b0;
            r_cam_addr   <= '0;
        end else begin
            if (cmd_if.cmd_valid && w_cmd_ready) begin
                r_op  <= cmd_if.cmd_op;
                r_key <= cmd_if.cmd_key;
            end
            if (r_state == S_SEARCH) begin
                r_match_addr <= i_cam_match_addr;
                r_alloc      <= w_free_idx;
            end
            r_valid_vec  <= w_valid_next;
            r_occupancy  <= w_occ_next;
            r_rsp_valid  <= (w_state_next == S_RESP);
            r_rsp_status <= w_rsp_status_next;
            r_rsp_addr   <= w_rsp_addr_next;
            // Strobes are one-hot by state, so enable and delete never overlap
            r_cam_we     <= (w_state_next == S_WRITE);
            r_cam_del    <= (w_state_next == S_DELETE);
            r_cam_clr    <= (w_state_next == S_CLR);
            if (w_state_next == S_WRITE) begin
                r_cam_addr <= w_free_idx;
            end else if (w_state_next == S_DELETE) begin
                r_cam_addr <= i_cam_match_addr;
            end
        end
    end

    assign cmd_if.cmd_ready   = w_cmd_ready;
    assign cmd_if.rsp_valid   = r_rsp_valid;
    assign cmd_if.rsp_status  = r_rsp_status;
    assign cmd_if.rsp_addr    = r_rsp_addr;
    assign o_occupancy        = r_occupancy;
    assign o_cam_write_addr   = r_cam_addr;
    assign o_cam_write_data   = r_key;
    assign o_cam_write_delete = r_cam_del;
    assign o_cam_write_enable = r_cam_we;
    assign o_cam_rst_clr      = r_cam_clr;
    assign o_cam_compare_data = r_key;
endmodule

// File: tb/tb_cam_manager.sv
// tb_cam_manager: directed plus random stimulus for cam_manager against a
// behavioural CAM and a key-table reference model.
module tb_cam_manager;
    import cam_manager_pkg::*;

    localparam int unsigned DW       = 16;
    localparam int unsigned AW       = 5;
    localparam int unsigned N        = 32;
    localparam int unsigned INIT_LEN = 18;
    localparam int unsigned CLR_LEN  = 18;
    localparam int unsigned DEL_LEN  = 2;
    localparam int unsigned TMO      = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cam_manager_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cif ();

    logic [AW:0]   occupancy;
    logic [AW-1:0] cam_waddr, cam_maddr;
    logic [DW-1:0] cam_wdata, cam_cmp;
    logic          cam_del, cam_we, cam_clr, cam_busy, cam_match;

    cam_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_if             (cif),
        .o_occupancy        (occupancy),
        .o_cam_write_addr   (cam_waddr),
        .o_cam_write_data   (cam_wdata),
        .o_cam_write_delete (cam_del),
        .o_cam_write_enable (cam_we),
        .o_cam_rst_clr      (cam_clr),
        .i_cam_write_busy   (cam_busy),
        .o_cam_compare_data (cam_cmp),
        .i_cam_match_addr   (cam_maddr),
        .i_cam_match        (cam_match)
    );

    // Behavioural CAM: combinational search, busy counter after each write-side strobe
    logic [DW-1:0] cam_key [N];
    logic [N-1:0]  cam_vld = '0;
    int unsigned   busy_cnt = 0;
    int unsigned   wr_busy_len = 1;
    assign cam_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= INIT_LEN;
            cam_vld  <= '0;
        end else if (cam_clr) begin
            busy_cnt <= CLR_LEN;
            cam_vld  <= '0;
        end else if (cam_we) begin
            cam_key[cam_waddr] <= cam_wdata;
            cam_vld[cam_waddr] <= 1'b1;
            busy_cnt           <= wr_busy_len;
        end else if (cam_del) begin
            cam_vld[cam_waddr] <= 1'b0;
            busy_cnt           <= DEL_LEN;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always_comb begin
        cam_match = 1'b0;
        cam_maddr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cam_vld[i] && cam_key[i] == cam_cmp) begin
                cam_match = 1'b1;
                cam_maddr = AW'(i);
            end
        end
    end

    // Cycle counter and strobe monitor
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned   we_cnt = 0, del_cnt = 0, clr_cnt = 0, both_cnt = 0, rsp_cnt = 0, we_cyc = 0;
    logic [AW-1:0] we_addr = '0, del_addr = '0;
    logic [DW-1:0] we_data = '0;
    always @(negedge clk) begin
        if (cam_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= cam_waddr;
            we_data <= cam_wdata;
            we_cyc  <= cyc;
        end
        if (cam_del) begin
            del_cnt  <= del_cnt + 1;
            del_addr <= cam_waddr;
        end
        if (cam_clr) clr_cnt <= clr_cnt + 1;
        if (cam_we && cam_del) both_cnt <= both_cnt + 1;
        if (cif.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // Reference model: a plain key table with lowest-free allocation
    logic [DW-1:0] ref_key [N];
    logic          ref_vld [N];

    task automatic ref_reset();
        for (int i = 0; i < N; i++) ref_vld[i] = 1'b0;
    endtask

    function automatic int ref_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (ref_vld[i]) c++;
        return c;
    endfunction

    task automatic ref_apply(input logic [1:0] op, input logic [DW-1:0] key,
                             output logic [1:0] st, output logic [AW-1:0] ad);
        int hit = -1;
        int free = -1;
        for (int i = 0; i < N; i++) begin
            if (ref_vld[i] && ref_key[i] == key && hit < 0) hit = i;
            if (!ref_vld[i] && free < 0) free = i;
        end
        st = ST_NOTFOUND;
        ad = '0;
        case (op)
            OP_INSERT: begin
                if (hit >= 0) begin
                    st = ST_DUP; ad = AW'(hit);
                end else if (free < 0) begin
                    st = ST_FULL;
                end else begin
                    st = ST_OK; ad = AW'(free);
                    ref_vld[free] = 1'b1; ref_key[free] = key;
                end
            end
            OP_DELETE, OP_LOOKUP: begin
                if (hit >= 0) begin
                    st = ST_OK; ad = AW'(hit);
                    if (op == OP_DELETE) ref_vld[hit] = 1'b0;
                end
            end
            default: begin
                ref_reset();
                st = ST_OK;
            end
        endcase
    endtask

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for its response and check it against the model
    task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] key,
                          output logic [1:0] st, output logic [AW-1:0] ad);
        int unsigned   we0, del0, clr0, acc, lat, n;
        logic [1:0]    est;
        logic [AW-1:0] ead;
        we0 = we_cnt; del0 = del_cnt; clr0 = clr_cnt;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_key   = key;
        n = 0;
        while (cif.cmd_ready !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < TMO), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'($urandom);
        cif.cmd_key   = DW'($urandom);
        ref_apply(op, key, est, ead);
        @(negedge clk);
        check("ready_low_T1", 32'(cif.cmd_ready), 32'd0);
        n = 0;
        while (cif.rsp_valid !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", 32'(n < TMO), 32'd1);
        lat = cyc - acc;
        st  = cif.rsp_status;
        ad  = cif.rsp_addr;
        check("rsp_status", 32'(cif.rsp_status), 32'(est));
        check("rsp_addr", 32'(cif.rsp_addr), 32'(ead));
        check("occupancy", 32'(occupancy), 32'(ref_count()));
        if (est != ST_OK || op == OP_LOOKUP) begin
            check("lat_immediate", lat, 32'd2);
        end else if (op == OP_INSERT) begin
            check("lat_insert", lat, 32'd5);
            check("we_at_T2", we_cyc - acc, 32'd2);
            check("we_addr", 32'(we_addr), 32'(ead));
            check("we_data", 32'(we_data), 32'(key));
        end else if (op == OP_DELETE) begin
            check("lat_delete_min", 32'(lat >= 6), 32'd1);
            check("del_addr", 32'(del_addr), 32'(ead));
        end else begin
            check("lat_clear_min", 32'(lat >= CLR_LEN), 32'd1);
        end
        @(negedge clk);
        check("rsp_single_pulse", 32'(cif.rsp_valid), 32'd0);
        #1;
        check("we_pulses", we_cnt - we0, 32'(op == OP_INSERT && est == ST_OK));
        check("del_pulses", del_cnt - del0, 32'(op == OP_DELETE && est == ST_OK));
        check("clr_pulses", clr_cnt - clr0, 32'(op == OP_CLEAR));
    endtask

    logic [1:0]    st;
    logic [AW-1:0] ad;
    logic [DW-1:0] pool [40];
    int unsigned   r, n, r0;
    logic [1:0]    rop;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = OP_INSERT;
        cif.cmd_key   = '0;
        ref_reset();
        for (int i = 0; i < 40; i++) pool[i] = DW'($urandom);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(cif.rsp_valid), 32'd0);
        check("rst_rsp_status", 32'(cif.rsp_status), 32'd0);
        check("rst_rsp_addr", 32'(cif.rsp_addr), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_strobes", 32'({cam_we, cam_del, cam_clr}), 32'd0);
        check("rst_compare", 32'(cam_cmp), 32'd0);
        check("rst_ready", 32'(cif.cmd_ready), 32'd0);
        rst = 1'b0;

        // CAM initialisation: command port stalls while busy
        cif.cmd_valid = 1'b1;
        n = 0;
        while (cam_busy && n < TMO) begin
            check("init_ready", 32'(cif.cmd_ready), 32'd0);
            check("init_occ", 32'(occupancy), 32'd0);
            check("init_rsp", 32'(cif.rsp_valid), 32'd0);
            @(negedge clk);
            n++;
        end
        cif.cmd_valid = 1'b0;
        check("init_done", 32'(n < TMO), 32'd1);
        check("ready_after_init", 32'(cif.cmd_ready), 32'd1);

        // Three inserts, lookups
        do_cmd(OP_INSERT, 16'h1234, st, ad);
        check("ins1234", {30'd0, st} << 8 | 32'(ad), 32'(ST_OK) << 8 | 32'd0);
        do_cmd(OP_INSERT, 16'h00AB, st, ad);
        check("ins00ab_addr", 32'(ad), 32'd1);
        do_cmd(OP_INSERT, 16'hFFFF, st, ad);
        check("insffff_addr", 32'(ad), 32'd2);
        check("occ_three", 32'(occupancy), 32'd3);
        do_cmd(OP_LOOKUP, 16'h00AB, st, ad);
        check("lookup_ab", {30'd0, st} << 8 | 32'(ad), 32'(ST_OK) << 8 | 32'd1);
        do_cmd(OP_LOOKUP, 16'h5555, st, ad);
        check("lookup_5555", 32'(st), 32'(ST_NOTFOUND));

        // Duplicate, delete and reuse
        do_cmd(OP_INSERT, 16'h1234, st, ad);
        check("dup_1234", {30'd0, st} << 8 | 32'(ad), 32'(ST_DUP) << 8 | 32'd0);
        do_cmd(OP_DELETE, 16'h00AB, st, ad);
        check("del_ab", {30'd0, st} << 8 | 32'(ad), 32'(ST_OK) << 8 | 32'd1);
        do_cmd(OP_INSERT, 16'h7777, st, ad);
        check("reuse_addr", 32'(ad), 32'd1);
        do_cmd(OP_DELETE, 16'h00AB, st, ad);
        check("del_ab_again", 32'(st), 32'(ST_NOTFOUND));

        // Fill, overflow, clear
        for (int i = 0; i < 29; i++) do_cmd(OP_INSERT, 16'h8000 + DW'(i), st, ad);
        check("occ_full", 32'(occupancy), 32'd32);
        do_cmd(OP_INSERT, 16'h4242, st, ad);
        check("full_status", 32'(st), 32'(ST_FULL));
        do_cmd(OP_CLEAR, 16'h0000, st, ad);
        check("clear_status", 32'(st), 32'(ST_OK));
        check("occ_cleared", 32'(occupancy), 32'd0);
        do_cmd(OP_LOOKUP, 16'h1234, st, ad);
        check("lookup_after_clear", 32'(st), 32'(ST_NOTFOUND));

        // Random mix over a small key pool to exercise dup/full/notfound
        for (int i = 0; i < 100; i++) begin
            r = $urandom_range(0, 99);
            rop = (r < 50) ? OP_INSERT : (r < 72) ? OP_LOOKUP : (r < 97) ? OP_DELETE : OP_CLEAR;
            do_cmd(rop, pool[$urandom_range(0, 39)], st, ad);
        end

        // Reset while an insert waits on busy
        wr_busy_len = 6;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = OP_INSERT;
        cif.cmd_key   = 16'hBEEF;
        n = 0;
        while (cif.cmd_ready !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_ready_wait", 32'(n < TMO), 32'd1);
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_busy_in_wait", 32'(cam_busy), 32'd1);
        r0  = rsp_cnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_reset();
        wr_busy_len = 1;
        n = 0;
        while (cif.cmd_ready !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_recover", 32'(n < TMO), 32'd1);
        #1;
        check("rstmid_no_rsp", rsp_cnt - r0, 32'd0);
        check("rstmid_occ", 32'(occupancy), 32'd0);
        do_cmd(OP_INSERT, 16'hBEEF, st, ad);
        check("rstmid_realloc", {30'd0, st} << 8 | 32'(ad), 32'(ST_OK) << 8 | 32'd0);

        check("we_del_exclusive", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
